wdt_window_ctrl: RTL and testbench

- Windowed watchdog supervisor that sequences a watchdog up-counter through closed-window, open-window, warning and bite phases.
- Services ("kicks") are accepted only through a two-beat key sequence.
- Raises a warning interrupt before expiry, then a fixed-length system-reset request on expiry or on an early/illegal service.
- Sits between the CPU register interface and the SoC reset controller.

---
 rtl/wdt_window_ctrl.sv | 166 ++++++++++++++++
 tb/tb_wdt_window_ctrl.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/wdt_window_ctrl.sv
// Windowed watchdog supervisor: closed/open/warn/bite phase sequencer with a
// two-beat service key and a fixed-length reset request on expiry or misuse.
module wdt_window_ctrl #(
  parameter int         CNT_WIDTH = 16,
  parameter int         RST_PULSE = 8,
  parameter logic [7:0] KEY1      = 8'hA5,
  parameter logic [7:0] KEY2      = 8'h5A,
  parameter int         DEF_WIN   = 4,
  parameter int         DEF_WARN  = 10,
  parameter int         DEF_TMO   = 15
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 cfg_we,
  input  logic [CNT_WIDTH-1:0] cfg_win,
  input  logic [CNT_WIDTH-1:0] cfg_warn,
  input  logic [CNT_WIDTH-1:0] cfg_tmo,
  input  logic                 enable,
  input  logic                 kick_valid,
  input  logic [7:0]           kick_data,
  output logic [CNT_WIDTH-1:0] count,
  output logic [2:0]           state,
  output logic                 locked,
  output logic                 warn_irq,
  output logic                 bite_rst,
  output logic                 err_early,
  output logic                 err_key,
  output logic                 err_cfg
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_CLOSED = 3'd1,
    S_OPEN   = 3'd2,
    S_WARN   = 3'd3,
    S_BITE   = 3'd4
  } state_t;

  localparam int BW = (RST_PULSE > 1) ? $clog2(RST_PULSE) : 1;
  localparam logic [BW-1:0] BITE_LAST = BW'(RST_PULSE - 1);

  state_t               state_q, state_nxt;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_nxt, cnt_inc;
  logic [CNT_WIDTH-1:0] win_q, win_nxt, warn_q, warn_nxt, tmo_q, tmo_nxt;
  logic [BW-1:0]        bcnt_q, bcnt_nxt;
  logic                 armed_q, armed_nxt;
  logic                 service, cfg_legal;
  logic                 ee_nxt, ek_nxt, ec_nxt;

  assign cnt_inc   = cnt_q + 1'b1;
  assign cfg_legal = (win_q != '0) && (win_q < warn_q) && (warn_q < tmo_q);

  always_comb begin
    state_nxt = state_q;
    cnt_nxt   = cnt_q;
    win_nxt   = win_q;
    warn_nxt  = warn_q;
    tmo_nxt   = tmo_q;
    bcnt_nxt  = bcnt_q;
    armed_nxt = armed_q;
    service   = 1'b0;
    ee_nxt    = 1'b0;
    ek_nxt    = 1'b0;
    ec_nxt    = 1'b0;

    // Key decoder runs in every phase except BITE, where beats are dropped.
    if (state_q == S_BITE) begin
      armed_nxt = 1'b0;
    end else if (kick_valid) begin
      if (!armed_q && kick_data == KEY1) begin
        armed_nxt = 1'b1;
      end else if (armed_q && kick_data == KEY2) begin
        service   = 1'b1;
        armed_nxt = 1'b0;
      end else begin
        ek_nxt    = 1'b1;
        armed_nxt = 1'b0;
      end
    end

    case (state_q)
      S_IDLE: begin
        if (cfg_we) begin
          win_nxt  = cfg_win;
          warn_nxt = cfg_warn;
          tmo_nxt  = cfg_tmo;
        end
        // Legality is judged on the registers as they stand before this edge.
        if (enable) begin
          if (cfg_legal) begin
            state_nxt = S_CLOSED;
            cnt_nxt   = '0;
          end else begin
            ec_nxt = 1'b1;
          end
        end
      end
      S_CLOSED, S_OPEN, S_WARN: begin
        if (service && state_q == S_CLOSED) begin
          state_nxt = S_BITE;
          ee_nxt    = 1'b1;
          bcnt_nxt  = '0;
        end else if (service) begin
          state_nxt = S_CLOSED;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt_inc;
          if (cnt_inc == tmo_q) begin
            state_nxt = S_BITE;
            bcnt_nxt  = '0;
          end else if (cnt_inc == warn_q) begin
            state_nxt = S_WARN;
          end else if (cnt_inc == win_q) begin
            state_nxt = S_OPEN;
          end
        end
      end
      S_BITE: begin
        if (bcnt_q == BITE_LAST) begin
          state_nxt = S_CLOSED;
          cnt_nxt   = '0;
          bcnt_nxt  = '0;
        end else begin
          bcnt_nxt = bcnt_q + 1'b1;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      win_q     <= CNT_WIDTH'(DEF_WIN);
      warn_q    <= CNT_WIDTH'(DEF_WARN);
      tmo_q     <= CNT_WIDTH'(DEF_TMO);
      bcnt_q    <= '0;
      armed_q   <= 1'b0;
      locked    <= 1'b0;
      warn_irq  <= 1'b0;
      bite_rst  <= 1'b0;
      err_early <= 1'b0;
      err_key   <= 1'b0;
      err_cfg   <= 1'b0;
    end else begin
      state_q   <= state_nxt;
      cnt_q     <= cnt_nxt;
      win_q     <= win_nxt;
      warn_q    <= warn_nxt;
      tmo_q     <= tmo_nxt;
      bcnt_q    <= bcnt_nxt;
      armed_q   <= armed_nxt;
      locked    <= (state_nxt != S_IDLE);
      warn_irq  <= (state_nxt == S_WARN);
      bite_rst  <= (state_nxt == S_BITE);
      err_early <= ee_nxt;
      err_key   <= ek_nxt;
      err_cfg   <= ec_nxt;
    end
  end

  assign count = cnt_q;
  assign state = state_q;

endmodule

// File: tb/tb_wdt_window_ctrl.sv
// Directed bench for wdt_window_ctrl: a vector table for start-up, service and
// key errors, plus hand sequences for bite, expiry, lock and async reset.
module tb_wdt_window_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       cfg_we, enable, kick_valid;
  logic [7:0] cfg_win, cfg_warn, cfg_tmo, kick_data;
  logic [7:0] count;
  logic [2:0] state;
  logic       locked, warn_irq, bite_rst, err_early, err_key, err_cfg;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  wdt_window_ctrl #(
    .CNT_WIDTH(8), .RST_PULSE(4), .KEY1(8'hA5), .KEY2(8'h5A),
    .DEF_WIN(4), .DEF_WARN(10), .DEF_TMO(15)
  ) dut (
    .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_win(cfg_win),
    .cfg_warn(cfg_warn), .cfg_tmo(cfg_tmo), .enable(enable),
    .kick_valid(kick_valid), .kick_data(kick_data), .count(count),
    .state(state), .locked(locked), .warn_irq(warn_irq), .bite_rst(bite_rst),
    .err_early(err_early), .err_key(err_key), .err_cfg(err_cfg)
  );

  typedef struct {
    logic       kv;
    logic [7:0] kd;
    logic       we;
    logic       en;
    logic [2:0] st;
    logic [7:0] cnt;
    logic       wi;
    logic       br;
    logic       ee;
    logic       ek;
    logic       ec;
  } vec_t;

  vec_t tbl[14];

  function automatic vec_t mk(logic kv, logic [7:0] kd, logic we, logic en,
                              logic [2:0] st, logic [7:0] cnt, logic wi,
                              logic br, logic ee, logic ek, logic ec);
    vec_t v;
    v.kv = kv; v.kd = kd; v.we = we; v.en = en; v.st = st; v.cnt = cnt;
    v.wi = wi; v.br = br; v.ee = ee; v.ek = ek; v.ec = ec;
    return v;
  endfunction

  function automatic logic [16:0] dut_outs();
    return {state, count, locked, warn_irq, bite_rst, err_early, err_key, err_cfg};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    cfg_we = 0; enable = 0; kick_valid = 0; kick_data = 8'h00;
  endtask

  task automatic kick(input logic [7:0] d);
    kick_valid = 1; kick_data = d;
    step();
    kick_valid = 0; kick_data = 8'h00;
  endtask

  task automatic do_reset();
    idle_in();
    rst_n = 0;
    step();
    step();
    rst_n = 1;
    step();
  endtask

  int n_bite, n_ee, c_open, c_warn, c_bite, hold_bad, guard;
  logic [16:0] exp_o;

  initial begin
    rst_n = 0;
    idle_in();
    cfg_win = 8'd4; cfg_warn = 8'd10; cfg_tmo = 8'd15;
    step();
    check("reset_outputs", 32'(dut_outs()), 32'd0);
    rst_n = 1;
    step();

    // Start-up, good service and bad-key vectors from a fresh IDLE.
    tbl[0]  = mk(0, 8'h00, 1, 0, 3'd0, 8'd0, 0, 0, 0, 0, 0);
    tbl[1]  = mk(0, 8'h00, 0, 1, 3'd1, 8'd0, 0, 0, 0, 0, 0);
    tbl[2]  = mk(0, 8'h00, 0, 0, 3'd1, 8'd1, 0, 0, 0, 0, 0);
    tbl[3]  = mk(0, 8'h00, 0, 0, 3'd1, 8'd2, 0, 0, 0, 0, 0);
    tbl[4]  = mk(0, 8'h00, 0, 0, 3'd1, 8'd3, 0, 0, 0, 0, 0);
    tbl[5]  = mk(0, 8'h00, 0, 0, 3'd2, 8'd4, 0, 0, 0, 0, 0);
    tbl[6]  = mk(0, 8'h00, 0, 0, 3'd2, 8'd5, 0, 0, 0, 0, 0);
    tbl[7]  = mk(1, 8'hA5, 0, 0, 3'd2, 8'd6, 0, 0, 0, 0, 0);
    tbl[8]  = mk(1, 8'h5A, 0, 0, 3'd1, 8'd0, 0, 0, 0, 0, 0);
    tbl[9]  = mk(1, 8'hA5, 0, 0, 3'd1, 8'd1, 0, 0, 0, 0, 0);
    tbl[10] = mk(1, 8'h33, 0, 0, 3'd1, 8'd2, 0, 0, 0, 1, 0);
    tbl[11] = mk(0, 8'h00, 0, 0, 3'd1, 8'd3, 0, 0, 0, 0, 0);
    tbl[12] = mk(1, 8'h5A, 0, 0, 3'd2, 8'd4, 0, 0, 0, 1, 0);
    tbl[13] = mk(0, 8'h00, 0, 0, 3'd2, 8'd5, 0, 0, 0, 0, 0);

    for (int i = 0; i < 14; i++) begin
      kick_valid = tbl[i].kv; kick_data = tbl[i].kd;
      cfg_we = tbl[i].we; enable = tbl[i].en;
      step();
      exp_o = {tbl[i].st, tbl[i].cnt, (tbl[i].st != 3'd0), tbl[i].wi,
               tbl[i].br, tbl[i].ee, tbl[i].ek, tbl[i].ec};
      check($sformatf("vec%0d", i), 32'(dut_outs()), 32'(exp_o));
    end
    idle_in();

    // Early service: A5 at count 1, 5A at count 2.
    do_reset();
    enable = 1; step(); enable = 0;
    step();
    check("early_pre_count", 32'(count), 32'd1);
    kick(8'hA5);
    kick(8'h5A);
    check("early_enter", {29'd0, state}, 32'd4);
    check("early_flags", {29'd0, err_early, bite_rst, locked}, 32'b111);
    n_bite = 1; n_ee = 1;
    for (int i = 0; i < 10 && bite_rst; i++) begin
      step();
      if (bite_rst) n_bite++;
      if (err_early) n_ee++;
    end
    check("early_bite_len", 32'(n_bite), 32'd4);
    check("early_pulse_len", 32'(n_ee), 32'd1);
    check("early_after", {21'd0, state, count}, {21'd0, 3'd1, 8'd0});

    // Missed service: expiry through OPEN, WARN and BITE with no kicks.
    c_open = -1; c_warn = -1; c_bite = -1; n_bite = 0; hold_bad = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (state == 3'd2 && c_open < 0) c_open = int'(count);
      if (state == 3'd3 && warn_irq && c_warn < 0) c_warn = int'(count);
      if (state == 3'd4 && c_bite < 0) c_bite = int'(count);
      if (bite_rst) begin
        n_bite++;
        if (count != 8'd15) hold_bad++;
      end
      if (c_bite >= 0 && state == 3'd1) break;
    end
    check("miss_open_at", 32'(c_open), 32'd4);
    check("miss_warn_at", 32'(c_warn), 32'd10);
    check("miss_bite_at", 32'(c_bite), 32'd15);
    check("miss_bite_len", 32'(n_bite), 32'd4);
    check("miss_count_hold", 32'(hold_bad), 32'd0);
    check("miss_after", {21'd0, state, count}, {21'd0, 3'd1, 8'd0});

    // Config write while running is ignored: phases stay at 4/10/15.
    cfg_we = 1; cfg_win = 8'd2; cfg_warn = 8'd3; cfg_tmo = 8'd5;
    step();
    cfg_we = 0; cfg_win = 8'd4; cfg_warn = 8'd10; cfg_tmo = 8'd15;
    step();
    check("lock_c2", {21'd0, state, count}, {21'd0, 3'd1, 8'd2});
    step(); step();
    check("lock_c4", {21'd0, state, count}, {21'd0, 3'd2, 8'd4});
    guard = 0;
    while (count != 8'd13 && guard < 30) begin
      step();
      guard++;
    end
    check("reach_13", 32'(count), 32'd13);
    kick(8'hA5);
    check("warn_at_14", {22'd0, state, count[7:0]} & 32'h7FF, {21'd0, 3'd3, 8'd14});
    kick(8'h5A);
    check("service_vs_tmo", {19'd0, state, count, warn_irq, bite_rst},
          {19'd0, 3'd1, 8'd0, 1'b0, 1'b0});

    // Async reset in the middle of a bite.
    kick(8'hA5);
    kick(8'h5A);
    check("bite_before_rst", {30'd0, bite_rst, state == 3'd4}, 32'b11);
    step();
    rst_n = 0;
    #1;
    check("async_rst", 32'(dut_outs()), 32'd0);
    step();
    rst_n = 1;
    step();

    // Illegal config, and cfg_we together with enable uses the old values.
    cfg_we = 1; cfg_win = 8'd9; cfg_warn = 8'd9; cfg_tmo = 8'd15;
    step();
    cfg_we = 0;
    enable = 1; step(); enable = 0;
    check("cfg_illegal", 32'(dut_outs()), 32'd1);
    step();
    check("cfg_pulse_end", 32'(dut_outs()), 32'd0);
    cfg_we = 1; cfg_win = 8'd4; cfg_warn = 8'd10; cfg_tmo = 8'd15; enable = 1;
    step();
    cfg_we = 0;
    check("cfg_same_cycle", 32'(dut_outs()), 32'd1);
    step();
    enable = 0;
    check("cfg_new_start", {21'd0, state, count}, {21'd0, 3'd1, 8'd0});

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
